// File: rtl/alu_pkg.sv
// Shared opcode and state types for alu_seq.
// ALU_MUL_EN makes opcode 1001 an iterative multiply.
package alu_pkg;

  typedef enum logic [3:0] {
    CMD_XOR   = 4'b0001,
    CMD_BNEZ  = 4'b0010,
    CMD_ADD   = 4'b0011,
    CMD_LSH   = 4'b0100,
    CMD_RSH   = 4'b0101,
    CMD_PASSB = 4'b0110,
    CMD_PASSA = 4'b0111,
    CMD_PARI  = 4'b1000,
    CMD_MUL   = 4'b1001,
    CMD_OR    = 4'b1010,
    CMD_SUB   = 4'b1011
  } alu_cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    MUL,
    HOLD
  } state_e;

  function automatic logic is_shift(input logic [3:0] cmd);
    return (cmd == CMD_LSH) || (cmd == CMD_RSH);
  endfunction

  function automatic logic is_iterative(input logic [3:0] cmd);
`ifdef ALU_MUL_EN
    return is_shift(cmd) || (cmd == CMD_MUL);
`else
    return is_shift(cmd);
`endif
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle datapath for the non-iterative alu_seq opcodes.
// Shifts, multiply and undefined opcodes return rslt=0, sc_o=0.
module alu_core
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int CMD_W = 4
) (
  input  logic [CMD_W-1:0] cmd,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             sc_i,
  output logic [W-1:0]     rslt,
  output logic             sc_o
);

  logic [W:0] sum;
  logic [W:0] diff;

  // Bit W of the widened difference is the borrow (b < a + sc_i).
  assign sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, sc_i};
  assign diff = {1'b0, b} - {1'b0, a} - {{W{1'b0}}, sc_i};

  always_comb begin
    rslt = '0;
    sc_o = 1'b0;
    case (cmd)
      CMD_W'(CMD_XOR):   rslt = a ^ b;
      CMD_W'(CMD_BNEZ):  rslt = {{(W-1){1'b0}}, |b};
      CMD_W'(CMD_ADD): begin
        rslt = sum[W-1:0];
        sc_o = sum[W];
      end
      CMD_W'(CMD_PASSB): rslt = b;
      CMD_W'(CMD_PASSA): rslt = a;
      CMD_W'(CMD_PARI):  rslt = {{(W-1){1'b0}}, ^b};
      CMD_W'(CMD_OR):    rslt = a | b;
      CMD_W'(CMD_SUB): begin
        rslt = diff[W-1:0];
        sc_o = diff[W];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked width-generic ALU with registered result and one-bit-per-cycle shifts.
// Define ALU_MUL_EN to add the iterative shift-add multiply on opcode 1001.
// state | meaning
// IDLE  | empty, ready to accept an op
// SHIFT | shifting rslt one bit per cycle, cnt bits remaining
// MUL   | shift-add multiply, cnt steps remaining
// HOLD  | result valid, waiting for out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int W     = 8,
  parameter int CMD_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMD_W-1:0] alu_cmd,
  input  logic [W-1:0]     inA,
  input  logic [W-1:0]     inB,
  input  logic             sc_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     rslt,
  output logic             sc_o,
  output logic             pari,
  output logic             zero
);

  localparam int CNT_W = $clog2(W) + 1;
  localparam logic [W-1:0] W_AMT = W'(W);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             shift_left;
  logic [3:0]       op;
  logic             op_ok;
  logic             accept;
  logic [CNT_W-1:0] shift_cnt;
  logic [W-1:0]     core_rslt;
  logic             core_sc;

  // op_ok rejects wide opcodes whose upper bits would alias a defined one.
  assign op        = 4'(alu_cmd);
  assign op_ok     = (alu_cmd == CMD_W'(op));
  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign pari      = ^rslt;
  assign zero      = (rslt == '0);
  assign shift_cnt = (inA >= W_AMT) ? CNT_W'(W) : inA[CNT_W-1:0];

  alu_core #(
    .W     (W),
    .CMD_W (CMD_W)
  ) u_core (
    .cmd  (alu_cmd),
    .a    (inA),
    .b    (inB),
    .sc_i (sc_i),
    .rslt (core_rslt),
    .sc_o (core_sc)
  );

`ifdef ALU_MUL_EN
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_next;
  logic [W-1:0]   mcand;
  logic [W:0]     mul_sum;

  assign mul_sum   = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {mul_sum, prod[W-1:1]};
`endif

  // rslt doubles as the shift accumulator; out_valid is low while it moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_left <= 1'b0;
      rslt       <= '0;
      sc_o       <= 1'b0;
`ifdef ALU_MUL_EN
      prod       <= '0;
      mcand      <= '0;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (shift_left) begin
            rslt <= {rslt[W-2:0], 1'b0};
            sc_o <= rslt[W-1];
          end else begin
            rslt <= {1'b0, rslt[W-1:1]};
            sc_o <= rslt[0];
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= HOLD;
        end
`ifdef ALU_MUL_EN
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            rslt  <= prod_next[W-1:0];
            sc_o  <= |prod_next[2*W-1:W];
            state <= HOLD;
          end
        end
`endif
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        IDLE: ;
        default: state <= IDLE;
      endcase

      // Accept overrides the HOLD retire above, giving back-to-back issue.
      if (accept) begin
        if (op_ok && is_iterative(op)) begin
          if (is_shift(op)) begin
            rslt       <= inB;
            sc_o       <= 1'b0;
            shift_left <= (op == CMD_LSH);
            cnt        <= shift_cnt;
            state      <= (inA == '0) ? HOLD : SHIFT;
          end
`ifdef ALU_MUL_EN
          else begin
            prod  <= {{W{1'b0}}, inB};
            mcand <= inA;
            cnt   <= CNT_W'(W);
            state <= MUL;
          end
`endif
        end else begin
          rslt  <= core_rslt;
          sc_o  <= core_sc;
          state <= HOLD;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at W=8.
// Opcode 1001 expectations follow whether ALU_MUL_EN is defined.
module tb_alu_seq;

  localparam int W     = 8;
  localparam int CMD_W = 4;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic             sc_i      = 1'b0;
  logic [CMD_W-1:0] alu_cmd   = '0;
  logic [W-1:0]     inA       = '0;
  logic [W-1:0]     inB       = '0;
  logic             in_ready;
  logic             out_valid;
  logic [W-1:0]     rslt;
  logic             sc_o;
  logic             pari;
  logic             zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(
    .W     (W),
    .CMD_W (CMD_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_cmd   (alu_cmd),
    .inA       (inA),
    .inB       (inB),
    .sc_i      (sc_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rslt      (rslt),
    .sc_o      (sc_o),
    .pari      (pari),
    .zero      (zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present an op and return #1 after the edge that accepted it.
  task automatic send(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                      input logic s);
    int n = 0;
    alu_cmd  = c;
    inA      = a;
    inB      = b;
    sc_i     = s;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] c, input logic [7:0] a,
                        input logic [7:0] b, input logic s, input logic [7:0] er,
                        input logic es, input int elat);
    int lat = 1;
    out_ready = 1'b1;
    send(c, a, b, s);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_rslt"}, 32'(rslt), 32'(er));
    chk({tag, "_sc"}, 32'(sc_o), 32'(es));
    chk({tag, "_pari"}, 32'(pari), 32'(^er));
    chk({tag, "_zero"}, 32'(zero), 32'(er == 8'h00));
    @(posedge clk); #1;
  endtask

  logic [3:0] s_cmd [8] = '{4'b1010, 4'b0111, 4'b0110, 4'b1010,
                            4'b0111, 4'b1010, 4'b0110, 4'b1111};
  logic [7:0] s_a   [8] = '{8'h01, 8'h22, 8'h99, 8'h80, 8'h00, 8'h0F, 8'h77, 8'h12};
  logic [7:0] s_b   [8] = '{8'h10, 8'h44, 8'h33, 8'h01, 8'hAB, 8'hF0, 8'h5A, 8'h34};
  logic [7:0] s_exp [8] = '{8'h11, 8'h22, 8'h33, 8'h81, 8'h00, 8'hFF, 8'h5A, 8'h00};

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_rslt", 32'(rslt), 0);
    chk("rst_sc", 32'(sc_o), 0);
    chk("rst_pari", 32'(pari), 0);
    chk("rst_zero", 32'(zero), 1);
    @(posedge clk); #1;

    // Reset two cycles into a 5-step shift: nothing may come out afterwards.
    out_ready = 1'b1;
    send(4'b0100, 8'd5, 8'h81, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_valid", 32'(out_valid), 0);
    chk("rstmid_rslt", 32'(rslt), 0);
    chk("rstmid_zero", 32'(zero), 1);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rstmid_ready", 32'(in_ready), 1);
    n = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    chk("rstmid_stale", 32'(n), 0);

    // Arithmetic and logic, latency 1.
    run_op("add_c",    4'b0011, 8'hF0, 8'h20, 1'b1, 8'h11, 1'b1, 1);
    run_op("add_nc",   4'b0011, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1);
    run_op("add_wrap", 4'b0011, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1);
    run_op("sub_brw",  4'b1011, 8'h05, 8'h03, 1'b0, 8'hFE, 1'b1, 1);
    run_op("sub_sci",  4'b1011, 8'h03, 8'h05, 1'b1, 8'h01, 1'b0, 1);
    run_op("sub_eq",   4'b1011, 8'h04, 8'h05, 1'b1, 8'h00, 1'b0, 1);
    run_op("xor",      4'b0001, 8'h0F, 8'hFF, 1'b1, 8'hF0, 1'b0, 1);
    run_op("bnez0",    4'b0010, 8'h55, 8'h00, 1'b0, 8'h00, 1'b0, 1);
    run_op("bnez1",    4'b0010, 8'h00, 8'h40, 1'b0, 8'h01, 1'b0, 1);
    run_op("pari",     4'b1000, 8'h00, 8'h07, 1'b0, 8'h01, 1'b0, 1);
    run_op("or",       4'b1010, 8'h0F, 8'h30, 1'b0, 8'h3F, 1'b0, 1);
    run_op("passa",    4'b0111, 8'hC3, 8'h11, 1'b1, 8'hC3, 1'b0, 1);
    run_op("undef0",   4'b0000, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1);

    // Iterative shifts: latency 1 + min(A, W).
    run_op("lsh1",     4'b0100, 8'd1,   8'h81, 1'b0, 8'h02, 1'b1, 2);
    run_op("rsh8",     4'b0101, 8'd8,   8'h81, 1'b0, 8'h00, 1'b1, 9);
    run_op("lsh8",     4'b0100, 8'd8,   8'h81, 1'b0, 8'h00, 1'b1, 9);
    run_op("lsh0",     4'b0100, 8'd0,   8'h5A, 1'b0, 8'h5A, 1'b0, 1);
    run_op("rsh3",     4'b0101, 8'd3,   8'h81, 1'b0, 8'h10, 1'b0, 4);
    run_op("lsh7",     4'b0100, 8'd7,   8'h81, 1'b0, 8'h80, 1'b0, 8);
    run_op("rsh200",   4'b0101, 8'd200, 8'h81, 1'b0, 8'h00, 1'b1, 9);

`ifdef ALU_MUL_EN
    run_op("mul_ovf",  4'b1001, 8'h10, 8'h10, 1'b0, 8'h00, 1'b1, 9);
    run_op("mul",      4'b1001, 8'h0F, 8'h0F, 1'b0, 8'hE1, 1'b0, 9);
`else
    run_op("mul_off",  4'b1001, 8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1);
`endif

    // Backpressure: xor result held while out_ready is low, next op queued.
    out_ready = 1'b0;
    send(4'b0001, 8'h0F, 8'hFF, 1'b0);
    alu_cmd  = 4'b1010;
    inA      = 8'h01;
    inB      = 8'h02;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_rslt", 32'(rslt), 32'h0F0);
      chk("bp_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_valid", 32'(out_valid), 1);
    chk("bp_next_rslt", 32'(rslt), 32'h03);
    @(posedge clk); #1;
    chk("bp_idle", 32'(out_valid), 0);

    // Back-to-back stream: one result per cycle, in order.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      alu_cmd  = s_cmd[i];
      inA      = s_a[i];
      inB      = s_b[i];
      sc_i     = 1'b1;
      in_valid = 1'b1;
      #1;
      chk("b2b_ready", 32'(in_ready), 1);
      @(posedge clk); #1;
      chk("b2b_valid", 32'(out_valid), 1);
      chk("b2b_rslt", 32'(rslt), 32'(s_exp[i]));
      chk("b2b_sc", 32'(sc_o), 0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_drain", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
